// File: rtl/kp_pkg.sv
// Shared keypoint definitions: field widths, entry layout {y, x} and the readout FSM states.
// Used by both the detect/filter writer and the stream readout.
package kp_pkg;

  localparam int KP_X_W   = 10;
  localparam int KP_Y_W   = 9;
  localparam int KP_W     = KP_X_W + KP_Y_W;
  localparam int KP_CNT_W = 11;
  localparam int KP_DEPTH = 2000;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Entry layout: y in the upper bits, x in the lower bits.
  localparam int KP_X_LSB = 0;
  localparam int KP_Y_LSB = KP_X_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR1 = 3'd1,
    ST_W0   = 3'd2,
    ST_W1   = 3'd3,
    ST_HDR2 = 3'd4,
    ST_DONE = 3'd5
  } kp_state_e;

  function automatic logic [KP_Y_W-1:0] kp_y(input logic [KP_W-1:0] e);
    return e[KP_Y_LSB +: KP_Y_W];
  endfunction

  function automatic logic [KP_X_W-1:0] kp_x(input logic [KP_W-1:0] e);
    return e[KP_X_LSB +: KP_X_W];
  endfunction

endpackage

// File: rtl/keypoint_stream_out.sv
// Serializes both keypoint memories onto the 16-bit output stream: header then {y},{x} per entry.
// out_data is a decode of registered state and the hold register; out_ready stalls hold everything.
module keypoint_stream_out #(
  parameter int         KP_DEPTH = kp_pkg::KP_DEPTH,
  parameter logic [3:0] HDR_TAG  = kp_pkg::HDR_TAG
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [kp_pkg::KP_CNT_W-1:0] kp1_count,
  input  logic [kp_pkg::KP_CNT_W-1:0] kp2_count,
  output logic [kp_pkg::KP_CNT_W-1:0] kp1_addr,
  output logic [kp_pkg::KP_CNT_W-1:0] kp2_addr,
  input  logic [kp_pkg::KP_W-1:0]     kp1_dout,
  input  logic [kp_pkg::KP_W-1:0]     kp2_dout,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [15:0]                 out_data,
  output logic                        busy,
  output logic                        done
);
  import kp_pkg::*;

  kp_state_e             state_q, state_d;
  logic                  set_q, set_d;
  logic [KP_CNT_W-1:0]   cnt1_q, cnt1_d;
  logic [KP_CNT_W-1:0]   cnt2_q, cnt2_d;
  logic [KP_CNT_W-1:0]   idx_q, idx_d;
  logic [KP_CNT_W-1:0]   addr1_q, addr1_d;
  logic [KP_CNT_W-1:0]   addr2_q, addr2_d;
  logic [KP_W-1:0]       hold_q, hold_d;

  logic                  xfer;
  logic [KP_CNT_W-1:0]   cur_cnt;
  logic [KP_W-1:0]       cur_dout;
  logic                  idx_more;
  logic [KP_CNT_W:0]     nxt2;
  logic [KP_CNT_W:0]     last_idx;
  logic                  addr_we;
  logic [KP_CNT_W-1:0]   addr_nxt;

  function automatic logic [KP_CNT_W-1:0] clamp_cnt(input logic [KP_CNT_W-1:0] c);
    if (int'(c) > KP_DEPTH) return KP_CNT_W'(KP_DEPTH);
    return c;
  endfunction

  assign out_valid = (state_q == ST_HDR1) || (state_q == ST_HDR2) ||
                     (state_q == ST_W0)   || (state_q == ST_W1);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign kp1_addr  = addr1_q;
  assign kp2_addr  = addr2_q;

  assign xfer     = out_valid && out_ready;
  assign cur_cnt  = set_q ? cnt2_q : cnt1_q;
  assign cur_dout = set_q ? kp2_dout : kp1_dout;
  assign idx_more = ({1'b0, idx_q} + 12'd1) < {1'b0, cur_cnt};
  assign nxt2     = {1'b0, idx_q} + 12'd2;
  assign last_idx = {1'b0, cur_cnt} - 12'd1;

  // Every word is a pure decode of registers, so a stall naturally holds it.
  always_comb begin
    out_data = 16'd0;
    case (state_q)
      ST_HDR1: out_data = {HDR_TAG, 1'b0, cnt1_q};
      ST_HDR2: out_data = {HDR_TAG, 1'b1, cnt2_q};
      ST_W0:   out_data = {7'd0, kp_y(hold_q)};
      ST_W1:   out_data = {6'd0, kp_x(hold_q)};
      default: out_data = 16'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    set_d    = set_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    idx_d    = idx_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    hold_d   = hold_q;
    addr_we  = 1'b0;
    addr_nxt = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt1_d  = clamp_cnt(kp1_count);
          cnt2_d  = clamp_cnt(kp2_count);
          set_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_HDR1;
        end
      end
      ST_HDR1, ST_HDR2: begin
        if (xfer) begin
          // Entry 0 is already on dout: the set's address has sat at 0.
          hold_d = cur_dout;
          idx_d  = '0;
          if (cur_cnt != '0) begin
            state_d  = ST_W0;
            addr_we  = 1'b1;
            addr_nxt = (cur_cnt > 11'd1) ? 11'd1 : 11'd0;
          end else if (state_q == ST_HDR1) begin
            state_d = ST_HDR2;
            set_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_W0: begin
        if (xfer) state_d = ST_W1;
      end
      ST_W1: begin
        if (xfer) begin
          hold_d  = cur_dout;
          addr_we = 1'b1;
          if (idx_more) begin
            idx_d    = idx_q + 11'd1;
            state_d  = ST_W0;
            addr_nxt = (nxt2 < last_idx) ? nxt2[KP_CNT_W-1:0] : last_idx[KP_CNT_W-1:0];
          end else begin
            addr_nxt = '0;
            if (!set_q) begin
              state_d = ST_HDR2;
              set_d   = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (addr_we) begin
      if (set_q) addr2_d = addr_nxt;
      else       addr1_d = addr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      set_q   <= 1'b0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      idx_q   <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      idx_q   <= idx_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: doc/keypoint_stream_out.md
# keypoint_stream_out

Readout stage that runs after keypoint detection and filtering. It reads the two keypoint memories (set 1 and set 2, 2000×19 each, one-cycle read latency) and serializes their contents onto the chip's 16-bit output stream `out_valid`/`out_data`. This is the transmitting end of the path that the detect/filter stage writes into. The top-level FSM pulses `start` once detection is done, then waits for `done`.

## Interface
Parameters:
- `KP_DEPTH`, 2000: entries per keypoint memory; counts are clamped to this value.
- `HDR_TAG`, 4'hA: tag placed in bits [15:12] of every header word.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: one-cycle request to begin a dump; ignored unless the block is in IDLE.
- `kp1_count`, `kp2_count`  in  11 each: number of valid entries per set; latched when `start` is accepted.
- `kp1_addr`, `kp2_addr`  out  11 each: registered read addresses.
- `kp1_dout`, `kp2_dout`  in  19 each: memory read data, valid one cycle after the address is presented. Layout is {y[8:0], x[9:0]}.
- `out_ready`  in  1: sink accepts the current word; the top level ties it to 1.
- `out_valid`  out  1: `out_data` holds a valid word.
- `out_data`  out  16: stream word.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the final word is accepted.

## Operation
- Stream format: for each set s (0 = set 1, 1 = set 2), in order:
  - header word {HDR_TAG, s, cnt[10:0]};
  - then for each entry i, from 0 to cnt-1: word0 = {7'd0, y}, word1 = {6'd0, x}.
- Total words per dump: 2 + 2·(c1 + c2).
- Counts: latched at `start`, then clamped: any value above KP_DEPTH becomes KP_DEPTH. The header carries the clamped value.
- States: IDLE → HDR1 → (W0 ↔ W1)×c1 → HDR2 → (W0 ↔ W1)×c2 → DONE → IDLE.
  - A header with cnt = 0 goes directly to the next header, or to DONE.
- Handshake:
  - A word is transferred on any cycle where `out_valid` and `out_ready` are both high.
  - While `out_valid` is high and `out_ready` is low, `out_data` and the state hold unchanged.
  - `out_valid` never drops without a transfer, except on reset.
- Prefetch:
  - The address register of the inactive set stays at 0, so entry 0 data is already on `dout` when that set's header is shown.
  - A 19-bit hold register captures `dout` when the header is accepted and when each W1 is accepted.
  - During W0 and W1 of entry i, the address shows min(i+1, cnt-1). The memory is static during readout, so a stalled address re-reads the same data.
  - Addresses never exceed cnt-1 and never exceed KP_DEPTH-1.
- `start` while `busy` is high is ignored. Changes to the count inputs after `start` have no effect.
- DONE lasts exactly one cycle: `done` = 1 and `out_valid` = 0.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `busy` = 0, `done` = 0, `kp1_addr` = `kp2_addr` = 0, state = IDLE, hold register = 0.
- Reset during a dump: everything returns to the reset values on the next edge. No partial word is emitted afterwards.
- `start` is sampled at edge 0. The header is on `out_valid`/`out_data` from cycle 1.
- With `out_ready` held at 1, word k appears at cycle 1+k with no bubbles: each W0/W1 pair takes 2 cycles.
- With `out_ready` = 1, `done` pulses at cycle 2·(c1+c2) + 3 and the block is back in IDLE at cycle 2·(c1+c2) + 4. A new `start` is accepted from that cycle on.
- Every output is registered; there is no combinational path from any input to `out_valid` or `out_data`.

## Structure
- Shared package `kp_pkg` holds:
  - constants KP_X_W = 10, KP_Y_W = 9, KP_W = 19, KP_CNT_W = 11, KP_DEPTH = 2000, HDR_TAG;
  - the keypoint field slice positions;
  - the state enum. The detect/filter writer uses the same package.
- No sub-module: one FSM, two address counters, one word counter, one hold register.

## Test plan
- c1 = 2, c2 = 1, `out_ready` = 1; mem1 = {(y5,x7), (y479,x639)}, mem2 = {(y0,x1)}:
  - stream is A002, 0005, 0007, 01DF, 027F, A801, 0000, 0001;
  - `done` pulses at cycle 9.
- c1 = c2 = 0: stream is A000 then A800; `done` pulses at cycle 3; neither address ever leaves 0.
- c1 = 3 with `out_ready` low for 3 cycles during the W0 of entry 1: `out_data` is stable throughout the stall, and the sink receives exactly 8 words (set 1: 1 header + 6, set 2 with c2 = 0: 1 header), no duplicates and none dropped.
- `start` pulsed again mid-dump, and `kp1_count` changed mid-dump: the stream is identical to an undisturbed run.
- `rst` asserted on the 4th word: next cycle `out_valid` = 0, `busy` = 0, both addresses = 0. A fresh `start` then produces the full correct stream.
- c1 = 2047: header is A7D0, the last set-1 address is 1999, and exactly 4000 data words follow the header.
